// File: rtl/rr_mux_arbiter_4.sv
// Four-requester round-robin arbiter feeding a shared 4:1 select and a
// one-entry registered output channel with valid/ready handshake.
module rr_mux_arbiter_4 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req_valid,
  output logic [3:0]   req_ready,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_sel
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [1:0]     r_ptr;
  logic [W-1:0]   r_data;
  logic [1:0]     r_sel;
  logic           w_can_load;
  logic           w_found;
  logic [1:0]     w_grant;
  logic           w_take;
  logic [W-1:0]   w_mux;

  assign out_valid = (r_state == FULL);
  assign out_data  = r_data;
  assign out_sel   = r_sel;

  // Round-robin scan from the pointer, grant decode, data select and next state.
  always_comb begin : p_arb
    logic [1:0] v_idx;
    w_can_load  = (r_state == EMPTY) | (out_ready & out_valid);
    w_found     = 1'b0;
    w_grant     = 2'd0;
    v_idx       = 2'd0;
    for (int k = 0; k < 4; k++) begin
      v_idx = r_ptr + 2'(k);
      if (!w_found && req_valid[v_idx]) begin
        w_found = 1'b1;
        w_grant = v_idx;
      end else begin
        w_found = w_found;
      end
    end
    w_take    = w_can_load & w_found & ~rst;
    req_ready = w_take ? (4'b0001 << w_grant) : 4'b0000;

    case (w_grant)
      2'd0:    w_mux = d0;
      2'd1:    w_mux = d1;
      2'd2:    w_mux = d2;
      2'd3:    w_mux = d3;
      default: w_mux = d0;
    endcase

    // A drain and a refill in the same cycle keep the register FULL.
    case (r_state)
      EMPTY:   w_state_nxt = w_take ? FULL : EMPTY;
      FULL: begin
        if (w_take) begin
          w_state_nxt = FULL;
        end else if (out_ready) begin
          w_state_nxt = EMPTY;
        end else begin
          w_state_nxt = FULL;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  // State, output register and priority pointer; pointer moves only on a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_data  <= '0;
      r_sel   <= 2'd0;
      r_ptr   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take) begin
        r_data <= w_mux;
        r_sel  <= w_grant;
        r_ptr  <= w_grant + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// Self-checking bench for rr_mux_arbiter_4: directed scenarios plus
// randomized traffic checked against a behavioural round-robin model.
module tb_rr_mux_arbiter_4;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [W-1:0] d [4];
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   out_sel;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_sel;
  int           m_ptr;

  rr_mux_arbiter_4 #(.W(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel)
  );

  always #5 clk = ~clk;

  function automatic int find_grant();
    for (int k = 0; k < 4; k++) begin
      if (req_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int g;
    if (rst || (m_valid && !out_ready)) return 4'b0000;
    g = find_grant();
    if (g < 0) return 4'b0000;
    return 4'(1 << g);
  endfunction

  function automatic void model_edge();
    int g;
    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0;
    end else begin
      g = find_grant();
      if (g >= 0 && (!m_valid || out_ready)) begin
        m_data = d[g]; m_sel = g; m_valid = 1'b1; m_ptr = (g + 1) % 4;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) d[i] = 4'(i + 1);
    tick(); tick();
    n_cmp++;
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 4'h0 || out_sel !== 2'd0) begin
      n_fail++; $display("FAIL reset_out: got v=%b d=%h s=%0d want 0/0/0", out_valid, out_data, out_sel);
    end
  endtask

  task automatic test_round_robin();
    logic [W-1:0] abcd [4];
    abcd[0] = 4'hA; abcd[1] = 4'hB; abcd[2] = 4'hC; abcd[3] = 4'hD;
    rst = 1'b0; req_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) d[i] = abcd[i];
    #1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (req_ready !== 4'(1 << (i % 4))) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b want %b", i, req_ready, 4'(1 << (i % 4))); end
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== abcd[i % 4] || out_sel !== 2'(i % 4)) begin
        n_fail++; $display("FAIL rr_out[%0d]: got v=%b d=%h s=%0d want 1/%h/%0d", i, out_valid, out_data, out_sel, abcd[i % 4], i % 4);
      end
    end
  endtask

  task automatic test_single_requester();
    req_valid = 4'b0100; d[2] = 4'd7; out_ready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready[%0d]: got %b want 0100", i, req_ready); end
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 4'd7 || out_sel !== 2'd2) begin
        n_fail++; $display("FAIL single_out[%0d]: got v=%b d=%h s=%0d want 1/7/2", i, out_valid, out_data, out_sel);
      end
    end
  endtask

  task automatic test_backpressure();
    req_valid = 4'b0010; d[1] = 4'd5; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; req_valid = 4'b1111; d[2] = 4'h9;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0000", i, req_ready); end
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 4'd5 || out_sel !== 2'd1) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v=%b d=%h s=%0d want 1/5/1", i, out_valid, out_data, out_sel);
      end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_release_ready: got %b want 0100", req_ready); end
    tick();
    n_cmp++;
    if (out_data !== 4'h9 || out_sel !== 2'd2) begin n_fail++; $display("FAIL bp_release_out: got d=%h s=%0d want 9/2", out_data, out_sel); end
  endtask

  task automatic test_wrap_skip();
    req_valid = 4'b0101; out_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL wrap_ready0: got %b want 0001", req_ready); end
    tick();
    n_cmp++;
    if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL wrap_ready2: got %b want 0100", req_ready); end
    tick();
    n_cmp++;
    if (out_sel !== 2'd2) begin n_fail++; $display("FAIL wrap_sel: got %0d want 2", out_sel); end
  endtask

  task automatic test_drain();
    req_valid = 4'b0000; out_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL drain_ready: got %b want 0000", req_ready); end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || out_sel !== 2'd2) begin n_fail++; $display("FAIL drain_out: got v=%b s=%0d want 0/2", out_valid, out_sel); end
    req_valid = 4'b1111;
    #1;
    n_cmp++;
    if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL drain_ptr: got %b want 1000", req_ready); end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    req_valid = 4'b0100; d[2] = 4'hC; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; req_valid = 4'b1111; rst = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_stall_ready: got %b want 0000", req_ready); end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 4'h0 || out_sel !== 2'd0) begin
      n_fail++; $display("FAIL rst_stall_out: got v=%b d=%h s=%0d want 0/0/0", out_valid, out_data, out_sel);
    end
    rst = 1'b0; out_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rst_stall_grant: got %b want 0001", req_ready); end
    tick();
  endtask

  task automatic test_random();
    logic [3:0] er;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) d[i] = 4'($urandom);
      req_valid = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 40) == 0);
      #1;
      er = exp_ready();
      n_cmp++;
      if (req_ready !== er) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b want %b", c, req_ready, er); end
      tick();
      n_cmp++;
      if (out_valid !== m_valid || out_data !== m_data || out_sel !== 2'(m_sel)) begin
        n_fail++; $display("FAIL rand_out[%0d]: got v=%b d=%h s=%0d want %b/%h/%0d", c, out_valid, out_data, out_sel, m_valid, m_data, m_sel);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0;
    #2;
    test_reset();
    test_round_robin();
    test_single_requester();
    test_backpressure();
    test_wrap_skip();
    test_drain();
    test_reset_mid_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
